// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and ALU control selector for the single-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_ctrl_e;

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: add/sub wrap, slt is signed and yields 0 or 1.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_ctrl_e   ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS subset: built-in ROM program, register file, data RAM and ALU.
module single_cycle_mips
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic [31:0] alu_result
);

    localparam int unsigned IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] mem_q  [DMEM_DEPTH];

    logic [IA_W-1:0] imem_idx;
    logic [DA_W-1:0] dmem_idx;
    logic [31:0]     instr;

    assign imem_idx = pc_q[IA_W+1:2];

    always_comb begin
        instr = '0;
        case (int'(imem_idx))
            0:  instr = 32'h2001_0005;
            1:  instr = 32'h2002_0003;
            2:  instr = 32'h0022_1820;
            3:  instr = 32'h0022_2022;
            4:  instr = 32'h0022_2824;
            5:  instr = 32'h0022_3025;
            6:  instr = 32'h0041_382A;
            7:  instr = 32'hAC03_0004;
            8:  instr = 32'h8C08_0004;
            9:  instr = 32'h1103_0001;
            10: instr = 32'h2009_0063;
            11: instr = 32'h0800_000B;
            default: instr = '0;
        endcase
    end

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, rs_val, rt_val;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];

    alu_ctrl_e  alu_ctrl;
    logic       alu_b_imm, reg_we, mem_we, mem_to_reg, is_beq, is_j;
    logic [4:0] wr_addr;

    always_comb begin
        alu_ctrl   = ALU_ZERO;
        alu_b_imm  = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        wr_addr    = rd;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: reg_we   = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_ctrl = ALU_ADD; alu_b_imm = 1'b1; reg_we = 1'b1; wr_addr = rt;
            end
            OP_LW: begin
                alu_ctrl = ALU_ADD; alu_b_imm = 1'b1; reg_we = 1'b1; wr_addr = rt;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_ctrl = ALU_ADD; alu_b_imm = 1'b1; mem_we = 1'b1;
            end
            OP_BEQ: begin
                alu_ctrl = ALU_SUB; is_beq = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    logic        alu_zero;
    logic [31:0] wr_data, pc_plus4;

    mips_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b_imm ? imm_sext : rt_val),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    assign dmem_idx = alu_result[DA_W+1:2];
    assign wr_data  = mem_to_reg ? mem_q[dmem_idx] : alu_result;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (is_beq && alu_zero) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
        else if (is_j)          pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            // $0 is never written, so it reads zero without a read-side mux
            if (reg_we && wr_addr != 5'd0) regs_q[wr_addr] <= wr_data;
            if (mem_we) mem_q[dmem_idx] <= rt_val;
        end
    end

    assign pc_out      = pc_q;
    assign instruction = instr;

endmodule

// File: tb/tb_single_cycle_mips.sv
// Scoreboard bench: an ISA-level reference model predicts each cycle's outputs and key state.
module tb_single_cycle_mips;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out, instruction, alu_result;

    always #5 clk = ~clk;

    single_cycle_mips #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .instruction (instruction),
        .alu_result  (alu_result)
    );

    typedef struct packed {
        logic [31:0] pc, ins, alu, r3, r7, r8, r9;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prog [64];
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [64];

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] fetch();
        return prog[(m_pc >> 2) % 64];
    endfunction

    function automatic logic [31:0] model_alu(input logic [31:0] ins);
        logic [31:0] a, b;
        a = m_regs[ins[25:21]];
        b = m_regs[ins[20:16]];
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
            6'h08, 6'h23, 6'h2B: return a + sext(ins[15:0]);
            6'h04: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic r);
        logic [31:0] ins, res, nxt;
        if (r) begin
            m_pc = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            for (int i = 0; i < 64; i++) m_mem[i] = 0;
            return;
        end
        ins = fetch();
        res = model_alu(ins);
        nxt = m_pc + 4;
        case (ins[31:26])
            6'h00: if (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A} && ins[15:11] != 0)
                       m_regs[ins[15:11]] = res;
            6'h08: if (ins[20:16] != 0) m_regs[ins[20:16]] = res;
            6'h23: if (ins[20:16] != 0) m_regs[ins[20:16]] = m_mem[(res >> 2) % 64];
            6'h2B: m_mem[(res >> 2) % 64] = m_regs[ins[20:16]];
            6'h04: if (res == 0) nxt = m_pc + 4 + (sext(ins[15:0]) << 2);
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic tick(input logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        model_step(r);
        e.pc  = m_pc;
        e.ins = fetch();
        e.alu = model_alu(e.ins);
        e.r3  = m_regs[3];
        e.r7  = m_regs[7];
        e.r8  = m_regs[8];
        e.r9  = m_regs[9];
        sb_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_out",      pc_out,           e.pc);
                check("instruction", instruction,      e.ins);
                check("alu_result",  alu_result,       e.alu);
                check("reg3",        dut.regs_q[3],    e.r3);
                check("reg7",        dut.regs_q[7],    e.r7);
                check("reg8",        dut.regs_q[8],    e.r8);
                check("reg9",        dut.regs_q[9],    e.r9);
            end
        end
    end

    initial begin : driver
        int budget;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = 32'h20010005; prog[1]  = 32'h20020003; prog[2]  = 32'h00221820;
        prog[3]  = 32'h00222022; prog[4]  = 32'h00222824; prog[5]  = 32'h00223025;
        prog[6]  = 32'h0041382A; prog[7]  = 32'hAC030004; prog[8]  = 32'h8C080004;
        prog[9]  = 32'h11030001; prog[10] = 32'h20090063; prog[11] = 32'h0800000B;
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = 0;

        tick(1'b1);
        tick(1'b1);
        repeat (20) tick(1'b0);

        // replay from reset, then reset again while pc_out is 24
        tick(1'b1);
        budget = 0;
        while (m_pc != 32'd24 && budget < 50) begin
            tick(1'b0);
            budget++;
        end
        checks++;
        if (m_pc != 32'd24) begin
            errors++;
            $display("FAIL midrun_reach_pc24: got %08h expected %08h", m_pc, 32'd24);
        end
        tick(1'b1);
        repeat (20) tick(1'b0);

        repeat (400) tick($urandom_range(0, 29) == 0);

        repeat (4) begin
            if (sb_q.size() > 0) @(negedge clk);
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
